// File: rtl/mem_rd_arbiter_pkg.sv
// Shared types and AXI constants for the memory read arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_AR, ARB_RD, ARB_DONE} arb_state_t;
    typedef enum logic [1:0] {OWN_I, OWN_D, OWN_UC} arb_owner_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    // Round-robin successor: ICACHE -> DCACHE -> UNCACHED -> ICACHE.
    function automatic arb_owner_t owner_after(arb_owner_t o);
        case (o)
            OWN_I:   return OWN_D;
            OWN_D:   return OWN_UC;
            default: return OWN_I;
        endcase
    endfunction

endpackage

// File: rtl/mem_rd_arbiter_if.sv
// Requester-side handshakes plus the AXI4 read channel of the arbiter.
interface mem_rd_arbiter_if #(
    parameter int LINE_WORDS = 8
);
    logic                        icache_rd_req;
    logic [31:0]                 icache_addr;
    logic                        icache_gnt;
    logic [LINE_WORDS-1:0][31:0] icache_data;

    logic                        dcache_rd_req;
    logic [31:0]                 dcache_addr;
    logic                        dcache_gnt;
    logic [LINE_WORDS-1:0][31:0] dcache_data;

    logic                        uc_rd_req;
    logic [31:0]                 uc_addr;
    logic                        uc_gnt;
    logic [31:0]                 uc_data;

    logic [3:0]                  arid;
    logic [31:0]                 araddr;
    logic [7:0]                  arlen;
    logic [2:0]                  arsize;
    logic [1:0]                  arburst;
    logic                        arvalid;
    logic                        arready;

    logic [3:0]                  rid;
    logic [31:0]                 rdata;
    logic [1:0]                  rresp;
    logic                        rlast;
    logic                        rvalid;
    logic                        rready;

    // Arbiter view.
    modport master (
        input  icache_rd_req, icache_addr, dcache_rd_req, dcache_addr, uc_rd_req, uc_addr,
        output icache_gnt, icache_data, dcache_gnt, dcache_data, uc_gnt, uc_data,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    // Requesters plus AXI slave view.
    modport slave (
        output icache_rd_req, icache_addr, dcache_rd_req, dcache_addr, uc_rd_req, uc_addr,
        input  icache_gnt, icache_data, dcache_gnt, dcache_data, uc_gnt, uc_data,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/mem_rd_arbiter_rr_arb3.sv
// Combinational 3-way round-robin picker starting the search at ptr.
module rr_arb3
    import mem_arb_pkg::*;
(
    input  logic [2:0] req,
    input  arb_owner_t ptr,
    output logic [2:0] grant,
    output arb_owner_t winner,
    output arb_owner_t next_ptr
);

    // Scan ptr, ptr+1, ptr+2 (mod 3) and take the first active request.
    always_comb begin
        logic found;
        int   idx;
        grant    = '0;
        winner   = ptr;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < 3; i++) begin
            idx = int'(ptr) + i;
            if (idx >= 3) idx = idx - 3;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = arb_owner_t'(idx[1:0]);
                next_ptr   = owner_after(arb_owner_t'(idx[1:0]));
            end
        end
    end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Shares one AXI4 read channel between I-cache, D-cache and uncached loads,
// one burst at a time, assembling beats into a line buffer.
module mem_rd_arbiter
    import mem_arb_pkg::*;
#(
    parameter int         LINE_WORDS = 8,
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic          clk,
    input  logic          rst,
    mem_rd_arbiter_if.master bus
);

    localparam int          CNT_W    = $clog2(LINE_WORDS);
    localparam logic [7:0]  LINE_LEN = 8'(LINE_WORDS - 1);
    localparam logic [31:0] OFF_MASK = 32'(LINE_WORDS * 4 - 1);

    arb_state_t                  state, state_nxt;
    arb_owner_t                  owner;
    arb_owner_t                  rr_ptr;
    logic [31:0]                 ar_addr;
    logic [7:0]                  ar_len;
    logic [CNT_W-1:0]            beat_cnt;
    logic [LINE_WORDS-1:0][31:0] line_buf;

    logic [2:0]  pick;
    arb_owner_t  pick_owner;
    arb_owner_t  pick_next;
    logic        any_req;
    logic [31:0] line_src;
    logic        last_beat;
    logic        unused_ok;

    rr_arb3 u_rr (
        .req      ({bus.uc_rd_req, bus.dcache_rd_req, bus.icache_rd_req}),
        .ptr      (rr_ptr),
        .grant    (pick),
        .winner   (pick_owner),
        .next_ptr (pick_next)
    );

    assign any_req   = |pick;
    assign line_src  = (pick_owner == OWN_D) ? bus.dcache_addr : bus.icache_addr;
    // rlast is the normal exit; the counter match guards against a missing rlast.
    assign last_beat = bus.rvalid && (bus.rlast || (8'(beat_cnt) == ar_len));
    // rid/rresp carry no meaning with a single outstanding burst and no error path.
    assign unused_ok = ^{bus.rid, bus.rresp};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ARB_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic for the IDLE -> AR -> RD -> DONE cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: if (any_req) state_nxt = ARB_AR;
            ARB_AR:   if (bus.arready) state_nxt = ARB_RD;
            ARB_RD:   if (last_beat) state_nxt = ARB_DONE;
            ARB_DONE: state_nxt = ARB_IDLE;
            default:  state_nxt = ARB_IDLE;
        endcase
    end

    // Latch the winner and its AR payload in IDLE; capture R beats in RD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner    <= OWN_I;
            rr_ptr   <= OWN_I;
            ar_addr  <= '0;
            ar_len   <= '0;
            beat_cnt <= '0;
            line_buf <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any_req) begin
                        owner    <= pick_owner;
                        rr_ptr   <= pick_next;
                        beat_cnt <= '0;
                        if (pick_owner == OWN_UC) begin
                            ar_addr <= bus.uc_addr;
                            ar_len  <= 8'd0;
                        end else begin
                            ar_addr <= line_src & ~OFF_MASK;
                            ar_len  <= LINE_LEN;
                        end
                    end
                end
                ARB_RD: begin
                    if (bus.rvalid) begin
                        line_buf[beat_cnt] <= bus.rdata;
                        beat_cnt           <= beat_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.arid    = AXI_ID;
    assign bus.araddr  = ar_addr;
    assign bus.arlen   = ar_len;
    assign bus.arsize  = AXI_SIZE_4B;
    assign bus.arburst = AXI_BURST_INCR;
    assign bus.arvalid = (state == ARB_AR);
    assign bus.rready  = (state == ARB_RD);

    // Grants come from registered state, so they are clean one-cycle pulses.
    assign bus.icache_gnt = (state == ARB_DONE) && (owner == OWN_I);
    assign bus.dcache_gnt = (state == ARB_DONE) && (owner == OWN_D);
    assign bus.uc_gnt     = (state == ARB_DONE) && (owner == OWN_UC);

    // Outputs read the buffer directly; it holds until the next burst's first beat.
    assign bus.icache_data = line_buf;
    assign bus.dcache_data = line_buf;
    assign bus.uc_data     = line_buf[0];

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Self-checking bench: requesters and AXI slave driven from one directed
// sequence with random payloads, checked against a round-robin reference model.
module tb_mem_rd_arbiter;

    localparam int LW = 8;

    logic clk;
    logic rst;
    logic clk_en;

    int total;
    int bad;
    int model_ptr;   // 0=I, 1=D, 2=UC: next slot the model searches from

    mem_rd_arbiter_if #(.LINE_WORDS(LW)) bus ();

    mem_rd_arbiter #(.LINE_WORDS(LW), .AXI_ID(4'd0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] gnt_vec();
        return {bus.uc_gnt, bus.dcache_gnt, bus.icache_gnt};
    endfunction

    // Reference arbitration: first pending slot searching from the pointer.
    function automatic int predict();
        logic [2:0] pend;
        int idx;
        pend = {bus.uc_rd_req, bus.dcache_rd_req, bus.icache_rd_req};
        for (int i = 0; i < 3; i++) begin
            idx = (model_ptr + i) % 3;
            if (pend[idx]) begin
                model_ptr = (idx + 1) % 3;
                return idx;
            end
        end
        return -1;
    endfunction

    // One complete transaction: AR check, beats, gnt check, hold check.
    task automatic serve(input int ar_dly, input int gap, input logic [31:0] base,
                         input bit rnd, input bit keep, output logic [2:0] gv_o);
        int          win;
        int          nb;
        bit          seen;
        logic [31:0] exp_addr;
        logic [31:0] words [LW];
        win = predict();
        chk("model_has_request", 32'(win >= 0), 32'd1);
        if (win < 0) win = 0;
        nb       = (win == 2) ? 1 : LW;
        exp_addr = (win == 0) ? (bus.icache_addr & ~32'h1F) :
                   (win == 1) ? (bus.dcache_addr & ~32'h1F) : bus.uc_addr;
        for (int k = 0; k < LW; k++) words[k] = rnd ? $urandom : base + 32'(k);

        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (bus.arvalid === 1'b1) seen = 1'b1;
        end
        chk("arvalid_timeout", 32'(seen), 32'd1);
        chk("araddr", bus.araddr, exp_addr);
        chk("arlen", 32'(bus.arlen), 32'(nb - 1));
        chk("arsize", 32'(bus.arsize), 32'd2);
        chk("arburst", 32'(bus.arburst), 32'd1);
        chk("arid", 32'(bus.arid), 32'd0);
        chk("rready_in_ar", 32'(bus.rready), 32'd0);
        repeat (ar_dly) begin
            @(negedge clk);
            chk("arvalid_hold", 32'(bus.arvalid), 32'd1);
            chk("araddr_hold", bus.araddr, exp_addr);
        end
        bus.arready = 1'b1;
        @(negedge clk);
        bus.arready = 1'b0;
        chk("arvalid_drop", 32'(bus.arvalid), 32'd0);
        chk("rready_in_rd", 32'(bus.rready), 32'd1);

        for (int k = 0; k < nb; k++) begin
            repeat (gap) begin
                bus.rvalid = 1'b0;
                @(negedge clk);
                chk("gnt_during_rd", 32'(gnt_vec()), 32'd0);
            end
            bus.rvalid = 1'b1;
            bus.rdata  = words[k];
            bus.rresp  = 2'($urandom);
            bus.rlast  = (k == nb - 1);
            @(negedge clk);
            bus.rvalid = 1'b0;
            bus.rlast  = 1'b0;
            if (k != nb - 1) chk("gnt_during_rd", 32'(gnt_vec()), 32'd0);
        end

        gv_o = gnt_vec();
        chk("gnt_owner", 32'(gv_o), 32'(3'b001 << win));
        for (int pass = 0; pass < 2; pass++) begin
            if (win == 2) chk("uc_data", bus.uc_data, words[0]);
            else if (win == 1)
                for (int k = 0; k < LW; k++) chk("dcache_data", bus.dcache_data[k], words[k]);
            else
                for (int k = 0; k < LW; k++) chk("icache_data", bus.icache_data[k], words[k]);
            if (pass == 0) begin
                if (!keep) begin
                    if (win == 0) bus.icache_rd_req = 1'b0;
                    if (win == 1) bus.dcache_rd_req = 1'b0;
                    if (win == 2) bus.uc_rd_req     = 1'b0;
                end
                @(negedge clk);
                chk("gnt_single_pulse", 32'(gnt_vec()), 32'd0);
            end
        end
    endtask

    initial begin
        logic [2:0] gv;
        bit         seen;
        total  = 0;
        bad    = 0;
        clk_en = 1'b0;
        rst    = 1'b0;
        bus.icache_rd_req = 1'b0; bus.icache_addr = '0;
        bus.dcache_rd_req = 1'b0; bus.dcache_addr = '0;
        bus.uc_rd_req     = 1'b0; bus.uc_addr     = '0;
        bus.arready = 1'b0;
        bus.rid = '0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 1'b0; bus.rvalid = 1'b0;

        // Reset with no clock running: outputs must clear immediately.
        #2 rst = 1'b1;
        #1;
        chk("reset_gnt", 32'(gnt_vec()), 32'd0);
        chk("reset_arvalid", 32'(bus.arvalid), 32'd0);
        chk("reset_rready", 32'(bus.rready), 32'd0);
        chk("reset_uc_data", bus.uc_data, 32'd0);
        chk("reset_line_word7", bus.icache_data[7], 32'd0);
        clk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;

        // I-cache refill, arready after 2 cycles, beats 0..7.
        bus.icache_addr   = 32'h1FC0_0040;
        bus.icache_rd_req = 1'b1;
        serve(2, 0, 32'd0, 1'b0, 1'b0, gv);

        // Uncached single-word load.
        bus.uc_addr   = 32'hBFAF_F004;
        bus.uc_rd_req = 1'b1;
        serve(0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, gv);
        chk("uc_arlen_zero_data", bus.uc_data, 32'hDEAD_BEEF);

        // All three held together: I, D, UC, then I again.
        bus.icache_addr = $urandom & ~32'h1F;
        bus.dcache_addr = $urandom & ~32'h1F;
        bus.uc_addr     = $urandom & ~32'h3;
        bus.icache_rd_req = 1'b1;
        bus.dcache_rd_req = 1'b1;
        bus.uc_rd_req     = 1'b1;
        serve(0, 0, 32'd0, 1'b1, 1'b1, gv); chk("order_1st_icache", 32'(gv), 32'b001);
        serve(1, 0, 32'd0, 1'b1, 1'b1, gv); chk("order_2nd_dcache", 32'(gv), 32'b010);
        serve(0, 1, 32'd0, 1'b1, 1'b1, gv); chk("order_3rd_uc", 32'(gv), 32'b100);
        serve(0, 0, 32'd0, 1'b1, 1'b1, gv); chk("order_4th_icache", 32'(gv), 32'b001);
        bus.icache_rd_req = 1'b0;
        bus.dcache_rd_req = 1'b0;
        bus.uc_rd_req     = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("idle_no_arvalid", 32'(bus.arvalid), 32'd0);
        end

        // Gapped beats with a slow arready.
        bus.dcache_addr   = 32'h8000_1260;
        bus.dcache_rd_req = 1'b1;
        serve(5, 1, 32'd0, 1'b1, 1'b0, gv);

        // Random mixes of requesters, payloads and timing.
        for (int it = 0; it < 8; it++) begin
            logic [2:0] m;
            m = 3'($urandom_range(1, 7));
            bus.icache_addr = $urandom & ~32'h1F;
            bus.dcache_addr = $urandom & ~32'h1F;
            bus.uc_addr     = $urandom & ~32'h3;
            bus.icache_rd_req = m[0];
            bus.dcache_rd_req = m[1];
            bus.uc_rd_req     = m[2];
            while (bus.icache_rd_req || bus.dcache_rd_req || bus.uc_rd_req)
                serve($urandom_range(0, 3), $urandom_range(0, 2), 32'd0, 1'b1, 1'b0, gv);
        end

        // Reset during beat 3 of a D-cache refill.
        bus.dcache_addr   = 32'h0000_4420;
        bus.dcache_rd_req = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (bus.arvalid === 1'b1) seen = 1'b1;
        end
        chk("rst_test_arvalid_timeout", 32'(seen), 32'd1);
        bus.arready = 1'b1;
        @(negedge clk);
        bus.arready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.rvalid = 1'b1;
            bus.rdata  = 32'hA000_0000 + 32'(k);
            @(negedge clk);
        end
        bus.rdata = 32'hA000_0003;
        #2 rst = 1'b1;
        #1;
        chk("midrst_rready", 32'(bus.rready), 32'd0);
        chk("midrst_arvalid", 32'(bus.arvalid), 32'd0);
        chk("midrst_gnt", 32'(gnt_vec()), 32'd0);
        chk("midrst_buf_clear", bus.dcache_data[0], 32'd0);
        bus.rvalid = 1'b0;
        bus.dcache_rd_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_gnt", 32'(gnt_vec()), 32'd0);
        end
        rst = 1'b0;
        model_ptr = 0;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_idle", 32'(bus.arvalid), 32'd0);
        end

        // Fresh transaction after reset.
        bus.uc_addr   = 32'h1234_5678;
        bus.uc_rd_req = 1'b1;
        serve(1, 0, 32'd0, 1'b1, 1'b0, gv);
        chk("post_rst_uc_gnt", 32'(gv), 32'b100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
